// File: rtl/dp_ram_fifo_ctrl_if.sv
// Push/pop streams plus the 1R/1W dual-port RAM strobes of the FIFO controller.
// LEVEL and ALMOST_FULL exist only when DP_FIFO_LEVEL_EN is defined.
interface dp_ram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  FLUSH;
    logic                  WR_VALID;
    logic                  WR_READY;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  RD_VALID;
    logic                  RD_READY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic [ADDR_WIDTH-1:0] AA;
    logic                  CEA;
    logic                  RDWENA;
    logic [ADDR_WIDTH-1:0] AB;
    logic [DATA_WIDTH-1:0] DB;
    logic [DATA_WIDTH-1:0] BWB;
    logic                  CEB;
    logic                  RDWENB;
    logic [DATA_WIDTH-1:0] QA;
`ifdef DP_FIFO_LEVEL_EN
    logic [ADDR_WIDTH+1:0] LEVEL;
    logic                  ALMOST_FULL;
`endif

    modport master (
        output FLUSH, WR_VALID, WR_DATA, RD_READY, QA,
        input  WR_READY, RD_VALID, RD_DATA,
        input  AA, CEA, RDWENA, AB, DB, BWB, CEB, RDWENB
`ifdef DP_FIFO_LEVEL_EN
        , input LEVEL, ALMOST_FULL
`endif
    );

    modport slave (
        input  FLUSH, WR_VALID, WR_DATA, RD_READY, QA,
        output WR_READY, RD_VALID, RD_DATA,
        output AA, CEA, RDWENA, AB, DB, BWB, CEB, RDWENB
`ifdef DP_FIFO_LEVEL_EN
        , output LEVEL, ALMOST_FULL
`endif
    );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller over a 1R/1W RAM with a 2-entry prefetch buffer (DEPTH+2 words).
// Define DP_FIFO_LEVEL_EN to add the registered LEVEL and ALMOST_FULL outputs.
module dp_ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
`ifdef DP_FIFO_LEVEL_EN
    , parameter int AFULL_THRESH = (2**ADDR_WIDTH)-2
`endif
) (
    input logic               CLK,
    input logic               RSTN,
    dp_ram_fifo_ctrl_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH+1;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  run_q;
    logic                  wr_ready;
    logic                  push;
    logic                  pop;
    logic                  issue;

    // run_q keeps WR_READY low until the first edge after reset release
    assign wr_ready = run_q & ~bus.FLUSH & (ram_cnt_q < CW'(DEPTH));
    assign push     = bus.WR_VALID & wr_ready;
    assign pop      = (occ_q != 2'd0) & bus.RD_READY;
    assign issue    = ~bus.FLUSH & (ram_cnt_q != '0) &
                      (({1'b0, occ_q} + {2'b00, inflight_q}) <
                       (3'd2 + {2'b00, pop}));

    always_comb begin
        wptr_d     = wptr_q + ADDR_WIDTH'(push);
        rptr_d     = rptr_q + ADDR_WIDTH'(issue);
        ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(issue);
        inflight_d = issue;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        occ_d      = occ_q;
        if (pop) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        // returning word lands behind whatever survives this cycle's pop
        if (inflight_q) begin
            if (occ_d == 2'd0) begin
                buf0_d = bus.QA;
            end else begin
                buf1_d = bus.QA;
            end
            occ_d = occ_d + 2'd1;
        end
        if (bus.FLUSH) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
            buf0_d     = '0;
            buf1_d     = '0;
            occ_d      = 2'd0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            occ_q      <= 2'd0;
            run_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            occ_q      <= occ_d;
            run_q      <= 1'b1;
        end
    end

    assign bus.WR_READY = wr_ready;
    assign bus.RD_VALID = (occ_q != 2'd0);
    assign bus.RD_DATA  = buf0_q;
    assign bus.AA       = rptr_q;
    assign bus.CEA      = issue;
    assign bus.RDWENA   = 1'b1;
    assign bus.AB       = wptr_q;
    assign bus.DB       = bus.WR_DATA;
    assign bus.BWB      = '1;
    assign bus.CEB      = push;
    assign bus.RDWENB   = ~push;

`ifdef DP_FIFO_LEVEL_EN
    localparam int LW = ADDR_WIDTH+2;

    logic [LW-1:0] level_q, level_d;
    logic          afull_q, afull_d;

    always_comb begin
        level_d = LW'(ram_cnt_d) + LW'(occ_d) + LW'(inflight_d);
        afull_d = (level_d >= LW'(AFULL_THRESH));
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= afull_d;
        end
    end

    assign bus.LEVEL       = level_q;
    assign bus.ALMOST_FULL = afull_q;
`endif
endmodule
